// File: rtl/intr_collector.sv
// intr_collector: turns rising edges on N interrupt lines into sticky pending
// bits, presents the lowest-numbered unmasked pending source over a
// valid/ready handshake, and counts edges lost while a source was pending.
// Optional feature: define INTR_COLLECTOR_SYNC_EN to pass each intr bit
// through a 2-flop synchronizer before edge detection (asynchronous sources).
module intr_collector #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CNTW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      intr,
  input  logic [N-1:0]      mask,
  output logic              irq_valid,
  output logic [IDW-1:0]    irq_id,
  input  logic              irq_ready,
  output logic              irq_any,
  output logic [N-1:0]      pending,
  output logic [N*CNTW-1:0] drop_cnt,
  input  logic              drop_clr
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    intr_s;
  logic [N-1:0]    intr_q, intr_d;
  logic [N-1:0]    intr_edge;
  logic [N-1:0]    req;
  logic [N-1:0]    clr;
  logic [N-1:0]    pending_q, pending_d;
  logic [IDW-1:0]  irq_id_q, irq_id_d;
  logic [IDW-1:0]  low_id;
  logic            irq_any_q, irq_any_d;
  logic [CNTW-1:0] cnt_q [N];
  logic [CNTW-1:0] cnt_d [N];

`ifdef INTR_COLLECTOR_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous interrupt sources
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= intr;
      sync2_q <= sync1_q;
    end
  end

  assign intr_s = sync2_q;
`else
  assign intr_s = intr;
`endif

  // Edge detect, grant-clear and sticky pending update (set wins over clear)
  always_comb begin
    intr_d    = intr_s;
    intr_edge = intr_s & ~intr_q;
    req       = pending_q & ~mask;
    irq_any_d = |req;
    clr       = '0;
    for (int i = 0; i < int'(N); i++) begin
      clr[i] = (state_q == PRESENT) && irq_ready && (irq_id_q == IDW'(i));
    end
    pending_d = (pending_q & ~clr) | intr_edge;
  end

  // Saturating drop counters; a clear pulse overrides any increment
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      cnt_d[i] = cnt_q[i];
      if (drop_clr) begin
        cnt_d[i] = '0;
      end else if (intr_edge[i] && pending_q[i] && !clr[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNTW'(1);
      end
    end
  end

  // Lowest-numbered unmasked pending source
  always_comb begin
    low_id = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        low_id = IDW'(i);
      end
    end
  end

  // Presentation FSM: latch a source in IDLE, hold it until accepted
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          irq_id_d = low_id;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      intr_q    <= '0;
      pending_q <= '0;
      irq_id_q  <= '0;
      irq_any_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      intr_q    <= intr_d;
      pending_q <= pending_d;
      irq_id_q  <= irq_id_d;
      irq_any_q <= irq_any_d;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Flatten the counter array onto the output bus
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      drop_cnt[i*CNTW +: CNTW] = cnt_q[i];
    end
  end

  assign irq_valid = (state_q == PRESENT);
  assign irq_id    = irq_id_q;
  assign irq_any   = irq_any_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_intr_collector.sv
// Bench for intr_collector (default build, no synchronizer): vector table,
// hand-written corner sequences, then random stimulus against a reference model.
module tb_intr_collector;

  localparam int unsigned N    = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned CNTW = 8;
  localparam int          CMAX = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      intr;
  logic [N-1:0]      mask;
  logic              irq_valid;
  logic [IDW-1:0]    irq_id;
  logic              irq_ready;
  logic              irq_any;
  logic [N-1:0]      pending;
  logic [N*CNTW-1:0] drop_cnt;
  logic              drop_clr;

  intr_collector #(.N(N), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .intr      (intr),
    .mask      (mask),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ready (irq_ready),
    .irq_any   (irq_any),
    .pending   (pending),
    .drop_cnt  (drop_cnt),
    .drop_clr  (drop_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state (only advanced while model_on is set)
  bit       model_on = 1'b0;
  bit [3:0] m_prev, m_pend;
  bit       m_valid, m_any;
  int       m_id;
  int       m_drop [4];

  typedef struct {
    logic [3:0] intr;
    logic [3:0] mask;
    logic       ready;
    logic       dclr;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [3:0] exp_pend;
    logic       exp_any;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Observable state with irq_id masked off while nothing is presented
  function automatic logic [63:0] observed();
    logic [1:0] id;
    id = irq_valid ? irq_id : 2'd0;
    return 64'({irq_valid, id, pending, irq_any, drop_cnt});
  endfunction

  function automatic logic [63:0] model_vec();
    logic [31:0] d;
    logic [1:0]  id;
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'(m_drop[i]);
    id = m_valid ? 2'(m_id) : 2'd0;
    return 64'({m_valid, id, m_pend, m_any, d});
  endfunction

  // One clock of the specified behaviour, from the inputs present at the edge
  task automatic model_step();
    bit [3:0] e, req, clr;
    bit       acc;
    e   = intr & ~m_prev;
    acc = m_valid && irq_ready;
    req = m_pend & ~mask;
    clr = acc ? (4'b0001 << m_id) : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (e[i] && m_pend[i] && !clr[i] && m_drop[i] < CMAX) m_drop[i]++;
      if (drop_clr) m_drop[i] = 0;
    end
    m_any  = (req != 0);
    m_pend = (m_pend & ~clr) | e;
    m_prev = intr;
    if (m_valid) begin
      if (irq_ready) m_valid = 1'b0;
    end else if (req != 0) begin
      m_valid = 1'b1;
      for (int i = 0; i < 4; i++) if (req[i]) begin m_id = i; break; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    #1;
  endtask

  int       grants;
  bit       stable;
  bit [3:0] flip;

  initial begin
    // intr, mask, ready, dclr | valid, id, pending, any
    tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[5]  = '{4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1010, 1'b0};
    tbl[6]  = '{4'b1010, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1010, 1'b1};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[11] = '{4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0};
    tbl[12] = '{4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};
    tbl[14] = '{4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    tbl[15] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};

    rst = 1'b0; intr = '0; mask = '0; irq_ready = 1'b0; drop_clr = 1'b0;
    #12;
    check("reset_state", observed(), 64'd0);
    tick();
    rst = 1'b1;

    // Single edge, priority and masking vectors
    for (int r = 0; r < 16; r++) begin
      intr = tbl[r].intr; mask = tbl[r].mask;
      irq_ready = tbl[r].ready; drop_clr = tbl[r].dclr;
      tick();
      check($sformatf("vec%0d", r), observed(),
            64'({tbl[r].exp_valid, tbl[r].exp_id, tbl[r].exp_pend, tbl[r].exp_any, 32'd0}));
    end

    // Backpressure on source 3 with 300 further edges: saturating drops
    mask = '0; irq_ready = 1'b0; drop_clr = 1'b0;
    intr = 4'b1000; tick();
    intr = 4'b0000; tick();
    check("bp_present", {62'd0, irq_valid, (irq_id == 2'd3)}, 64'd3);
    stable = 1'b1;
    for (int k = 0; k < 300; k++) begin
      intr = 4'b1000; tick();
      if (!(irq_valid && irq_id == 2'd3)) stable = 1'b0;
      intr = 4'b0000; tick();
      if (!(irq_valid && irq_id == 2'd3)) stable = 1'b0;
      if (k == 0) check("drop_first", 64'(drop_cnt), 64'h0100_0000);
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("drop_sat", 64'(drop_cnt), 64'hFF00_0000);
    drop_clr = 1'b1; tick();
    drop_clr = 1'b0;
    check("drop_clr", 64'(drop_cnt), 64'd0);
    intr = 4'b1000; drop_clr = 1'b1; tick();
    check("drop_clr_collide", 64'(drop_cnt), 64'd0);
    intr = 4'b0000; drop_clr = 1'b0; tick();
    check("bp_after_clr", observed(), 64'({1'b1, 2'd3, 4'b1000, 1'b1, 32'd0}));
    irq_ready = 1'b1; tick();
    check("bp_accept", 64'({irq_valid, pending}), 64'd0);
    irq_ready = 1'b0; tick();

    // Set/clear collision on source 1
    intr = 4'b0010; tick();
    intr = 4'b0000; tick();
    check("col_present", 64'({irq_valid, irq_id}), 64'({1'b1, 2'd1}));
    intr = 4'b0010; irq_ready = 1'b1; tick();
    check("col_edge", 64'({irq_valid, pending, drop_cnt}), 64'({1'b0, 4'b0010, 32'd0}));
    irq_ready = 1'b0; tick();
    check("col_repres", 64'({irq_valid, irq_id}), 64'({1'b1, 2'd1}));
    irq_ready = 1'b1; tick();
    check("col_done", 64'({irq_valid, pending}), 64'd0);
    intr = 4'b0000; irq_ready = 1'b0; tick();

    // Asynchronous reset while presenting, with source 0 held high across it
    intr = 4'b0001; tick();
    tick();
    intr = 4'b0000; tick();
    intr = 4'b0001; tick();
    check("rst_pre", observed(), 64'({1'b1, 2'd0, 4'b0001, 1'b1, 32'h0000_0001}));
    #2 rst = 1'b0;
    #1;
    check("rst_async", observed(), 64'd0);
    irq_ready = 1'b1;
    tick();
    rst = 1'b1;
    grants = 0;
    stable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (irq_valid) begin
        grants++;
        if (irq_id != 2'd0) stable = 1'b0;
      end
    end
    check("rst_one_grant", 64'(grants), 64'd1);
    check("rst_grant_id", 64'(stable), 64'd1);

    // Random stimulus against the reference model
    rst = 1'b0; intr = '0; mask = '0; irq_ready = 1'b0; drop_clr = 1'b0;
    tick();
    m_prev = '0; m_pend = '0; m_valid = 1'b0; m_any = 1'b0; m_id = 0;
    for (int i = 0; i < 4; i++) m_drop[i] = 0;
    model_on = 1'b1;
    rst = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      flip = 4'($urandom) & 4'($urandom);
      intr = intr ^ flip;
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom) & 4'($urandom);
      irq_ready = ($urandom_range(0, 9) < (((k / 500) % 2) != 0 ? 2 : 8));
      drop_clr  = ($urandom_range(0, 63) == 0);
      tick();
      check($sformatf("rand%0d", k), observed(), model_vec());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
